dac_frame_sequencer: RTL and testbench
======================================

DAC_FRAME_SEQUENCER -- requirements
Module: dac_frame_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, max cycles from o_dac_send to i_dac_ready low before abandoning the word.
REQ-002 SHALL have parameter SIGNED_IN, default 1; 1 = inputs two's complement, converted to offset binary; 0 = inputs already offset binary.
REQ-003 SHALL have i_clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_sample_valid  input  1  one-cycle strobe; i_sample_a/i_sample_b valid.
REQ-006 SHALL have i_sample_a, i_sample_b  input  16 each  channel A/B samples.
REQ-007 SHALL have i_dac_ready  input  1  downstream SPI serializer idle/ready.
REQ-008 SHALL have o_dac_data  output  24  command word to serializer.
REQ-009 SHALL have o_dac_send  output  1  one-cycle send strobe.
REQ-010 SHALL have o_frame_done, o_overrun, o_timeout  output  1 each  one-cycle status pulses.
REQ-011 SHALL have o_idle  output  1  high only in IDLE with pending slot empty.

Function
REQ-012 SHALL hold one pending slot {a,b,full}; i_sample_valid writes both samples and sets full.
REQ-013 SHALL, on i_sample_valid while full, overwrite slot (latest wins) and pulse o_overrun the next cycle.
REQ-014 SHALL, when i_sample_valid coincides with slot being consumed, keep new data and leave full set; no o_overrun.
REQ-015 SHALL convert sample d as d ^ 16'h8000 when SIGNED_IN=1, unchanged otherwise.
REQ-016 SHALL format channel A word {8'h00, sample} (write input register A) and B word {8'h11... no: 8'h11 is wrong; B word SHALL be {8'h11, sample}} -- resolved: A = {8'h00, a}, B = {8'h11, b} (write B, update both outputs).
REQ-017 SHALL use states IDLE, SEND, WAIT_ACK, WAIT_DONE plus word index (A, B, INIT0, INIT1).
REQ-018 IDLE: if full and i_dac_ready, latch slot into working regs, clear full, index=A, go SEND.
REQ-019 SEND: drive o_dac_data for index, pulse o_dac_send one cycle, go WAIT_ACK; o_dac_data SHALL hold stable until WAIT_DONE exits.
REQ-020 WAIT_ACK: i_dac_ready low -> WAIT_DONE; counter reaching ACK_TIMEOUT -> pulse o_timeout, drop frame, go IDLE.
REQ-021 WAIT_DONE: i_dac_ready high -> if index A, index=B, go SEND; if B, pulse o_frame_done, go IDLE.
REQ-022 SHALL never assert o_dac_send while i_dac_ready is low.
REQ-023 Frame from IDLE (slot full, ready high) to o_dac_send for A SHALL take exactly 2 cycles.
REQ-024 Timeout counter SHALL be 8 bits, cleared on entry to WAIT_ACK, saturating.

Reset
REQ-025 Reset low SHALL immediately force: o_dac_data=0, o_dac_send=0, all pulses 0, slot empty, counter 0, o_idle=0.
REQ-026 After release, state SHALL be IDLE (or INIT0 if macro defined); o_idle=1 from first IDLE cycle with empty slot.
REQ-027 Reset mid-frame SHALL abandon the frame; no o_frame_done, no further o_dac_send.

Configuration
REQ-028 Macro DAC_INIT_SEQ_EN defined: after reset SHALL send INIT0=24'h280001 (software reset) then INIT1=24'h380001 (internal reference on) via SEND/WAIT_ACK/WAIT_DONE, then IDLE; samples arriving meanwhile are held in the slot; o_frame_done not pulsed for init.
REQ-029 Macro DAC_INIT_SEQ_EN undefined: no init words; reset goes straight to IDLE; init logic absent.

Verification
REQ-030 Single frame: SIGNED_IN=1, a=16'h0000, b=16'h8000, ready model -> o_dac_data 24'h008000 then 24'h110000, two sends, one o_frame_done.
REQ-031 Overrun: two i_sample_valid during one frame (a=1 then a=2) -> one o_overrun, next frame sends 24'h008002.
REQ-032 Timeout: i_dac_ready stuck high after send -> o_timeout at cycle ACK_TIMEOUT (64), state IDLE, no o_frame_done.
REQ-033 Reset asserted during WAIT_DONE of word B -> outputs zero same cycle, no o_frame_done, no send after release until new valid.
REQ-034 DAC_INIT_SEQ_EN defined: reset release -> sends 24'h280001, 24'h380001, then pending sample frame; undefined -> first send is sample word A.

Source files
------------

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer
// Turns a pair of 16-bit channel samples into two 24-bit DAC command words
// (write input register A, then write B and update both outputs) and hands
// them one at a time to an SPI serializer. It uses a send strobe and watches
// the serializer's ready line go low (accepted) and high again (finished).
// A single pending slot buffers the next sample pair; the latest sample wins.
// Optional macro DAC_INIT_SEQ_EN: after reset, send a software-reset word and
// an internal-reference-on word before the first sample frame.
`timescale 1ns/1ps
module dac_frame_sequencer #(
  parameter int ACK_TIMEOUT = 64,
  parameter bit SIGNED_IN   = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample_a,
  input  logic [15:0] i_sample_b,
  input  logic        i_dac_ready,
  output logic [23:0] o_dac_data,
  output logic        o_dac_send,
  output logic        o_frame_done,
  output logic        o_overrun,
  output logic        o_timeout,
  output logic        o_idle
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

`ifdef DAC_INIT_SEQ_EN
  typedef enum logic [1:0] {IDX_A = 2'd0, IDX_B = 2'd1, IDX_INIT0 = 2'd2, IDX_INIT1 = 2'd3} word_idx_t;
  localparam state_t    RESET_STATE = SEND;
  localparam word_idx_t RESET_IDX   = IDX_INIT0;
`else
  typedef enum logic [1:0] {IDX_A = 2'd0, IDX_B = 2'd1} word_idx_t;
  localparam state_t    RESET_STATE = IDLE;
  localparam word_idx_t RESET_IDX   = IDX_A;
`endif

  // Last counter value tolerated while ready stays high after a send.
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  word_idx_t   idx, idx_nxt;
  logic [7:0]  ack_cnt, ack_cnt_nxt;
  logic        slot_full, slot_full_nxt;
  logic [15:0] slot_a, slot_a_nxt, slot_b, slot_b_nxt;
  logic [15:0] work_a, work_a_nxt, work_b, work_b_nxt;
  logic [23:0] data_nxt;
  logic        send_nxt, done_nxt, overrun_nxt, timeout_nxt;
  logic        consume;

  // Two's complement to offset binary is a flip of the sign bit.
  function automatic logic [15:0] to_dac_code(input logic [15:0] d);
    return SIGNED_IN ? (d ^ 16'h8000) : d;
  endfunction

  function automatic logic [23:0] frame_word(input word_idx_t sel,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [23:0] w;
    case (sel)
      IDX_A:     w = {8'h00, to_dac_code(a)};
      IDX_B:     w = {8'h11, to_dac_code(b)};
`ifdef DAC_INIT_SEQ_EN
      IDX_INIT0: w = 24'h280001;
      IDX_INIT1: w = 24'h380001;
`endif
      default:   w = 24'h000000;
    endcase
    return w;
  endfunction

  // Next-state, slot and output-pulse decisions.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    ack_cnt_nxt   = ack_cnt;
    work_a_nxt    = work_a;
    work_b_nxt    = work_b;
    data_nxt      = o_dac_data;
    send_nxt      = 1'b0;
    done_nxt      = 1'b0;
    timeout_nxt   = 1'b0;
    overrun_nxt   = 1'b0;
    slot_a_nxt    = slot_a;
    slot_b_nxt    = slot_b;
    slot_full_nxt = slot_full;
    consume       = 1'b0;

    case (state)
      IDLE: begin
        if (slot_full && i_dac_ready) begin
          consume    = 1'b1;
          work_a_nxt = slot_a;
          work_b_nxt = slot_b;
          idx_nxt    = IDX_A;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        // Holding here while ready is low keeps the strobe off a busy serializer.
        if (i_dac_ready) begin
          data_nxt    = frame_word(idx, work_a, work_b);
          send_nxt    = 1'b1;
          ack_cnt_nxt = 8'd0;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!i_dac_ready) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt >= ACK_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (ack_cnt != 8'hFF) begin
          ack_cnt_nxt = ack_cnt + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (i_dac_ready) begin
          case (idx)
            IDX_A: begin
              idx_nxt   = IDX_B;
              state_nxt = SEND;
            end
            IDX_B: begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
`ifdef DAC_INIT_SEQ_EN
            IDX_INIT0: begin
              idx_nxt   = IDX_INIT1;
              state_nxt = SEND;
            end
            IDX_INIT1: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new sample arriving as the slot is consumed simply refills it.
    if (consume) slot_full_nxt = 1'b0;
    if (i_sample_valid) begin
      slot_a_nxt    = i_sample_a;
      slot_b_nxt    = i_sample_b;
      slot_full_nxt = 1'b1;
      overrun_nxt   = slot_full && !consume;
    end
  end

  // Control state and registered outputs; reset clears everything visible.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= RESET_STATE;
      idx          <= RESET_IDX;
      ack_cnt      <= 8'd0;
      slot_full    <= 1'b0;
      o_dac_data   <= 24'd0;
      o_dac_send   <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      ack_cnt      <= ack_cnt_nxt;
      slot_full    <= slot_full_nxt;
      o_dac_data   <= data_nxt;
      o_dac_send   <= send_nxt;
      o_frame_done <= done_nxt;
      o_overrun    <= overrun_nxt;
      o_timeout    <= timeout_nxt;
    end
  end

  // Sample storage needs no reset: slot_full and the state decide its meaning.
  always_ff @(posedge i_clock) begin
    slot_a <= slot_a_nxt;
    slot_b <= slot_b_nxt;
    work_a <= work_a_nxt;
    work_b <= work_b_nxt;
  end

  // Idle is forced low while reset is held, even though the state reads IDLE.
  assign o_idle = i_reset_n && (state == IDLE) && !slot_full;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: a serializer responder drives the ready
// line, and a word-queue reference model predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_dac_frame_sequencer;
  localparam int ACK_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_a = 16'd0, sample_b = 16'd0;
  logic        dac_ready = 1'b1;
  logic [23:0] dac_data;
  logic        dac_send, frame_done, overrun, timeout, idle;

  dac_frame_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .SIGNED_IN(1'b1)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_sample_valid(sample_valid),
    .i_sample_a(sample_a), .i_sample_b(sample_b), .i_dac_ready(dac_ready),
    .o_dac_data(dac_data), .o_dac_send(dac_send), .o_frame_done(frame_done),
    .o_overrun(overrun), .o_timeout(timeout), .o_idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // stimulus controls
  logic        nx_valid = 1'b0, nx_rst_n = 1'b0;
  logic [15:0] nx_a = 16'd0, nx_b = 16'd0;
  bit          stuck = 1'b0, idle_noise = 1'b0;
  int          busy_fixed = 0, busy_left = 0;

  // observations
  logic [23:0] sent_words[$];
  int n_send = 0, n_done = 0, n_over = 0, n_tout = 0;

  // reference model: words still to send in the current frame
  localparam int M_IDLE = 0, M_SEND = 1, M_ACK = 2, M_DONE = 3;
  int          m_phase = M_IDLE, m_waited = 0;
  logic [23:0] m_words[$];
  bit          m_init_frame = 1'b0;
  logic        m_full = 1'b0;
  logic [15:0] m_sa = 16'd0, m_sb = 16'd0;
  logic [23:0] e_data = 24'd0;
  logic        e_send = 0, e_done = 0, e_over = 0, e_tout = 0, e_idle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] word_a(input logic [15:0] a);
    return {8'h00, a ^ 16'h8000};
  endfunction
  function automatic logic [23:0] word_b(input logic [15:0] b);
    return {8'h11, b ^ 16'h8000};
  endfunction

  function automatic logic [23:0] word_at(input int i);
    if (i < sent_words.size()) return sent_words[i];
    return 'x;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_full = 1'b0;
    m_waited = 0;
    m_init_frame = 1'b0;
    m_phase = M_IDLE;
`ifdef DAC_INIT_SEQ_EN
    m_words.push_back(24'h280001);
    m_words.push_back(24'h380001);
    m_init_frame = 1'b1;
    m_phase = M_SEND;
`endif
    e_data = 24'd0; e_send = 0; e_done = 0; e_over = 0; e_tout = 0; e_idle = 0;
  endtask

  // Predict outputs after the next rising edge from the inputs now applied.
  task automatic model_step(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic rdy);
    bit took;
    took = 1'b0;
    e_send = 0; e_done = 0; e_over = 0; e_tout = 0;
    case (m_phase)
      M_IDLE: if (m_full && rdy) begin
        took = 1'b1;
        m_words.delete();
        m_words.push_back(word_a(m_sa));
        m_words.push_back(word_b(m_sb));
        m_init_frame = 1'b0;
        m_phase = M_SEND;
      end
      M_SEND: if (rdy) begin
        e_data = m_words.pop_front();
        e_send = 1'b1;
        m_waited = 0;
        m_phase = M_ACK;
      end
      M_ACK: begin
        if (!rdy) m_phase = M_DONE;
        else begin
          m_waited++;
          if (m_waited >= ACK_TIMEOUT) begin
            e_tout = 1'b1;
            m_words.delete();
            m_phase = M_IDLE;
          end
        end
      end
      M_DONE: if (rdy) begin
        if (m_words.size() > 0) m_phase = M_SEND;
        else begin
          e_done = !m_init_frame;
          m_phase = M_IDLE;
        end
      end
      default: m_phase = M_IDLE;
    endcase
    if (took) m_full = 1'b0;
    if (v) begin
      e_over = m_full;
      m_sa = a;
      m_sb = b;
      m_full = 1'b1;
    end
    e_idle = (m_phase == M_IDLE) && !m_full;
  endtask

  // One clock: compare at the falling edge, then drive and advance the model.
  task automatic tick();
    logic sent;
    @(negedge clk);
    chk("dac_data", dac_data, e_data);
    chk("dac_send", dac_send, e_send);
    chk("frame_done", frame_done, e_done);
    chk("overrun", overrun, e_over);
    chk("timeout", timeout, e_tout);
    chk("idle", idle, e_idle);
    sent = dac_send;
    if (dac_send) begin
      chk("send_while_ready", dac_ready, 1);
      n_send++;
      sent_words.push_back(dac_data);
    end
    if (frame_done) n_done++;
    if (overrun) n_over++;
    if (timeout) n_tout++;

    rst_n = nx_rst_n;
    sample_valid = nx_valid;
    sample_a = nx_a;
    sample_b = nx_b;
    nx_valid = 1'b0;
    if (!rst_n) busy_left = 0;
    if (stuck) dac_ready = 1'b1;
    else if (sent) begin
      dac_ready = 1'b1;
      busy_left = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 4));
    end else if (busy_left > 0) begin
      dac_ready = 1'b0;
      busy_left--;
    end else dac_ready = (idle_noise && $urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;

    if (!rst_n) begin
      #1;
      chk("rst_dac_data", dac_data, 0);
      chk("rst_dac_send", dac_send, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_idle", idle, 0);
      model_reset();
    end else begin
      model_step(sample_valid, sample_a, sample_b, dac_ready);
    end
  endtask

  task automatic clear_obs();
    sent_words.delete();
    n_send = 0; n_done = 0; n_over = 0; n_tout = 0;
  endtask

  task automatic wait_sends(input int target, input int max, output int waited);
    waited = 0;
    while (n_send < target && waited < max) begin
      tick();
      waited++;
    end
    if (n_send < target) chk("wait_send_bound", n_send, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t;
    model_reset();
    nx_rst_n = 1'b0;
    repeat (3) tick();
    clear_obs();
    nx_rst_n = 1'b1;
    repeat (20) tick();
`ifdef DAC_INIT_SEQ_EN
    chk("init_sends", n_send, 2);
    chk("init_word0", word_at(0), 24'h280001);
    chk("init_word1", word_at(1), 24'h380001);
    chk("init_no_done", n_done, 0);
`else
    chk("no_send_after_reset", n_send, 0);
`endif
    chk("idle_after_reset", idle, 1);

    // single frame, latency from strobe to first send
    clear_obs();
    busy_fixed = 2;
    nx_valid = 1'b1; nx_a = 16'h0000; nx_b = 16'h8000;
    tick();
    wait_sends(1, 10, lat);
    chk("frame_latency", lat, 3);
    repeat (20) tick();
    chk("f1_sends", n_send, 2);
    chk("f1_word_a", word_at(0), 24'h008000);
    chk("f1_word_b", word_at(1), 24'h110000);
    chk("f1_done", n_done, 1);

    // overrun: two strobes during one frame, latest wins
    clear_obs();
    busy_fixed = 6;
    nx_valid = 1'b1; nx_a = 16'd5; nx_b = 16'd6;
    tick();
    wait_sends(1, 10, t);
    nx_valid = 1'b1; nx_a = 16'd1; nx_b = 16'd3;
    tick();
    nx_valid = 1'b1; nx_a = 16'd2; nx_b = 16'd3;
    tick();
    repeat (60) tick();
    chk("ovr_count", n_over, 1);
    chk("ovr_sends", n_send, 4);
    chk("ovr_w0", word_at(0), 24'h008005);
    chk("ovr_w1", word_at(1), 24'h118006);
    chk("ovr_w2", word_at(2), 24'h008002);
    chk("ovr_w3", word_at(3), 24'h118003);
    chk("ovr_done", n_done, 2);

    // timeout: ready never drops after the send
    clear_obs();
    busy_fixed = 0;
    stuck = 1'b1;
    nx_valid = 1'b1; nx_a = 16'h1234; nx_b = 16'h5678;
    tick();
    wait_sends(1, 10, t);
    t = 0;
    while (n_tout == 0 && t < 200) begin
      tick();
      t++;
    end
    chk("timeout_cycles", t, ACK_TIMEOUT);
    chk("timeout_sends", n_send, 1);
    chk("timeout_no_done", n_done, 0);
    tick();
    chk("timeout_idle", idle, 1);
    stuck = 1'b0;
    repeat (5) tick();

    // reset while word B is being shifted out
    clear_obs();
    busy_fixed = 8;
    nx_valid = 1'b1; nx_a = 16'h00AA; nx_b = 16'h00BB;
    tick();
    wait_sends(2, 40, t);
    chk("rst_b_word", word_at(1), 24'h1180BB);
    repeat (3) tick();
    nx_rst_n = 1'b0;
    tick();
    repeat (2) tick();
    clear_obs();
    nx_rst_n = 1'b1;
    busy_fixed = 0;
    repeat (20) tick();
`ifdef DAC_INIT_SEQ_EN
    chk("post_reset_sends", n_send, 2);
`else
    chk("post_reset_sends", n_send, 0);
`endif
    chk("post_reset_done", n_done, 0);

    // randomized traffic with a jittery serializer
    clear_obs();
    idle_noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        nx_valid = 1'b1;
        nx_a = 16'($urandom);
        nx_b = 16'($urandom);
      end
      tick();
    end
    idle_noise = 1'b0;
    repeat (30) tick();
    chk("random_activity", n_send > 20, 1);
    chk("random_frames", n_done > 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
